// File: rtl/matrix_pkg.sv
// Shared definitions for the paired ROM-C add path: parameter defaults,
// controller state encoding and common data types.
package matrix_pkg;

    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 17;
    localparam int PAIRS     = 64;
    localparam int READ_LAT  = 3;
    localparam int WR_ADDR_W = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } pair_ctrl_state_t;

    typedef logic [ADDR_W-1:0] rom_addr_t;
    typedef logic [DATA_W-1:0] pair_sum_t;

endpackage

// File: rtl/matrix_c_pair_reader_ctrl_valid_delay_line.sv
// Fixed-depth shift register that tracks which address cycles will
// produce a sum worth keeping, plus an occupancy flag for drain control.
module valid_delay_line #(
    parameter int DEPTH = matrix_pkg::READ_LAT
) (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic out,
    output logic any_set
);

    logic [DEPTH-1:0] r_pipe;

    // Shift a new valid bit in each clock; bit DEPTH-1 lines up with the adder output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= in;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign out     = r_pipe[DEPTH-1];
    assign any_set = |r_pipe;

endmodule

// File: rtl/matrix_c_pair_reader_ctrl.sv
// Issues paired ROM-C word addresses to the pair adder, tracks its fixed
// read latency and writes each pair sum sequentially into the result RAM.
module matrix_c_pair_reader_ctrl #(
    parameter int ADDR_W    = matrix_pkg::ADDR_W,
    parameter int DATA_W    = matrix_pkg::DATA_W,
    parameter int PAIRS     = matrix_pkg::PAIRS,
    parameter int READ_LAT  = matrix_pkg::READ_LAT,
    parameter int WR_ADDR_W = matrix_pkg::WR_ADDR_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 hold,
    output logic [ADDR_W-1:0]    Q_C,
    output logic [ADDR_W-1:0]    Qnext_C,
    output logic                 done_counter,
    input  logic [DATA_W-1:0]    result_add_matrix,
    output logic                 wr_en,
    output logic [WR_ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 busy,
    output logic                 done
);

    import matrix_pkg::*;

    // Pair index k; the word addresses are k with a 0 or 1 appended.
    localparam int K_W = ADDR_W - 1;

    pair_ctrl_state_t     r_state;
    pair_ctrl_state_t     w_next_state;
    logic [K_W-1:0]       r_k;
    logic [WR_ADDR_W-1:0] r_wcnt;
    logic                 r_done_counter;
    logic                 r_wr_en;
    logic [WR_ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0]    r_wr_data;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_issue_v;
    logic                 w_last_pair;
    logic                 w_tail;
    logic                 w_any_set;

    assign w_last_pair = (r_k == K_W'(PAIRS - 1));

    valid_delay_line #(
        .DEPTH (READ_LAT)
    ) u_valid_pipe (
        .clock   (clock),
        .reset   (reset),
        .in      (w_issue_v),
        .out     (w_tail),
        .any_set (w_any_set)
    );

    // Next-state decode; a stalled cycle pushes a 0 so its duplicate sum is dropped.
    always_comb begin
        w_next_state = r_state;
        w_issue_v    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = ISSUE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ISSUE: begin
                w_issue_v = ~hold;
                if (!hold && w_last_pair) begin
                    w_next_state = DRAIN;
                end else begin
                    w_next_state = ISSUE;
                end
            end
            DRAIN: begin
                // Pipe empty means the final write is on the RAM port this cycle.
                if (!w_any_set) begin
                    w_next_state = FINISH;
                end else begin
                    w_next_state = DRAIN;
                end
            end
            FINISH: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register and status outputs, registered from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_done_counter <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_busy         <= (w_next_state == ISSUE) || (w_next_state == DRAIN);
            r_done         <= (w_next_state == FINISH);
            r_done_counter <= (w_next_state == DRAIN) || (w_next_state == FINISH);
        end
    end

    // Pair index: cleared on a run start, advanced on each unstalled issue.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_k <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_k <= '0;
        end else if ((r_state == ISSUE) && !hold && !w_last_pair) begin
            r_k <= r_k + K_W'(1);
        end
    end

    // Write-back: capture the sum when the matching valid bit leaves the pipe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wcnt    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_tail;
            if (w_tail) begin
                r_wr_addr <= r_wcnt;
                r_wr_data <= result_add_matrix;
                r_wcnt    <= r_wcnt + WR_ADDR_W'(1);
            end else if ((r_state == IDLE) && start) begin
                r_wcnt <= '0;
            end
        end
    end

    assign Q_C          = {r_k, 1'b0};
    assign Qnext_C      = {r_k, 1'b1};
    assign done_counter = r_done_counter;
    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule
